// File: rtl/multicycle_core_ctrl_pkg.sv
// Shared types for the multi-cycle core sequencer: FSM states, next-PC and
// writeback select encodings.
package multicycle_core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    FAULT = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_REL  = 2'b01,
    PC_BR   = 2'b10,
    PC_JALR = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b01,
    WB_LINK = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/multicycle_core_ctrl_next_pc.sv
// Combinational next-PC target selection and word-alignment check.
module next_pc_calc
  import multicycle_core_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_base,
  input  pc_sel_t         sel,
  input  logic            branch_taken,
  output logic [XLEN-1:0] link,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] rel;
  logic [XLEN-1:0] jsum;

  assign link = pc + XLEN'(PC_STEP);
  assign rel  = pc + imm;
  assign jsum = jalr_base + imm;

  always_comb begin
    target = link;
    unique case (sel)
      PC_SEQ:  target = link;
      PC_REL:  target = rel;
      PC_BR:   target = branch_taken ? rel : link;
      PC_JALR: target = {jsum[XLEN-1:1], 1'b0};
      default: target = link;
    endcase
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle fetch/exec sequencer: owns PC, IR, retired count and
// writeback select; fetches over a ready/valid imem with a timeout.
module multicycle_core_ctrl
  import multicycle_core_ctrl_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          PC_STEP      = 4,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic [1:0]      pc_jmp_dec,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            wr_en_dec,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] alu_result,
  output logic            rf_wr_en,
  output logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret,
  output logic            fault
);

  localparam int TW = $clog2(IMEM_TIMEOUT + 2);

  ctrl_state_t     state;
  logic [TW-1:0]   tcnt;
  logic [XLEN-1:0] link, target;
  logic            misaligned;
  logic            timeout_hit;

  next_pc_calc #(.XLEN(XLEN), .PC_STEP(PC_STEP)) u_npc (
    .pc          (pc),
    .imm         (imm),
    .jalr_base   (jalr_base),
    .sel         (pc_sel_t'(pc_jmp_dec)),
    .branch_taken(branch_taken),
    .link        (link),
    .target      (target),
    .misaligned  (misaligned)
  );

  // tcnt holds the cycles already spent in FETCH+WAIT; this cycle is the
  // IMEM_TIMEOUT-th once tcnt reaches IMEM_TIMEOUT-1, where it saturates.
  assign timeout_hit = (IMEM_TIMEOUT != 0) && (tcnt >= TW'(IMEM_TIMEOUT - 1));

  assign imem_req_addr = pc;
  assign rf_wr_en      = (state == EXEC) && wr_en_dec && !misaligned;

  always_comb begin
    unique case (wb_sel_t'(wb_sel))
      WB_LINK: wr_data = link;
      WB_IMM:  wr_data = imm;
      default: wr_data = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= XLEN'(RESET_PC);
      instr          <= '0;
      instret        <= '0;
      tcnt           <= '0;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      fault          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (enable) begin
          state          <= FETCH;
          imem_req_valid <= 1'b1;
          tcnt           <= '0;
        end
        FETCH: begin
          if (!timeout_hit) tcnt <= tcnt + TW'(1);
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end else if (timeout_hit) begin
            state          <= FAULT;
            imem_req_valid <= 1'b0;
            fault          <= 1'b1;
          end
        end
        WAIT: begin
          if (!timeout_hit) tcnt <= tcnt + TW'(1);
          if (imem_rsp_valid) begin
            state       <= EXEC;
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            state <= FAULT;
            fault <= 1'b1;
          end
        end
        EXEC: begin
          instr_valid <= 1'b0;
          if (misaligned) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pc      <= target;
            instret <= instret + XLEN'(1);
            if (enable) begin
              state          <= FETCH;
              imem_req_valid <= 1'b1;
              tcnt           <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        FAULT: ;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Randomized self-checking bench for multicycle_core_ctrl against a
// per-instruction reference model of PC, retire count and fault.
module tb_multicycle_core_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, instr;
  logic        instr_valid, branch_taken, wr_en_dec, rf_wr_en, fault;
  logic [1:0]  pc_jmp_dec, wb_sel;
  logic [31:0] imm, jalr_base, alu_result, wr_data, pc, instret;

  int          checks = 0, errors = 0;
  logic [31:0] mpc, mret;
  bit          mfault;

  always #5 clk = ~clk;

  multicycle_core_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr(instr), .instr_valid(instr_valid),
    .pc_jmp_dec(pc_jmp_dec), .branch_taken(branch_taken), .imm(imm),
    .jalr_base(jalr_base), .wr_en_dec(wr_en_dec), .wb_sel(wb_sel),
    .alu_result(alu_result), .rf_wr_en(rf_wr_en), .wr_data(wr_data),
    .pc(pc), .instret(instret), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; pc_jmp_dec = '0; branch_taken = 1'b0; imm = '0;
    jalr_base = '0; wr_en_dec = 1'b0; wb_sel = '0; alu_result = '0;
    step; step;
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_fault", fault, 32'h0);
    chk("rst_reqv", imem_req_valid, 32'h0);
    chk("rst_iv", instr_valid, 32'h0);
    chk("rst_rfwe", rf_wr_en, 32'h0);
    mpc = 32'h0; mret = 32'h0; mfault = 1'b0;
  endtask

  task automatic hold_fault(input int n);
    repeat (n) begin
      imem_req_ready = 1'($urandom); imem_rsp_valid = 1'($urandom); enable = 1'($urandom);
      step;
      chk("flt_hold", fault, 32'h1);
      chk("flt_reqv", imem_req_valid, 32'h0);
      chk("flt_iv", instr_valid, 32'h0);
      chk("flt_pc", pc, mpc);
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
  endtask

  // Entered with the DUT in its first FETCH cycle; leaves it in FETCH again
  // unless the instruction faulted.
  task automatic run_instr(input int rdy_dly, input int rsp_dly, input logic [1:0] jmp,
                           input logic bt, input logic [31:0] im, input logic [31:0] base,
                           input logic [31:0] alu, input logic wren, input logic [1:0] wbs,
                           input bit en_after, input int idle_cyc);
    int          cyc, k;
    bit          to, bad;
    logic [31:0] data, tgt, wexp;
    cyc = 0; to = 1'b0; k = 0; data = '0;
    forever begin
      cyc++;
      chk("fetch_reqv", imem_req_valid, 32'h1);
      chk("fetch_addr", imem_req_addr, mpc);
      chk("fetch_iv", instr_valid, 32'h0);
      imem_req_ready = (k == rdy_dly);
      imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom; enable = 1'($urandom);
      step;
      if (k == rdy_dly) break;
      if (cyc >= TO) begin to = 1'b1; break; end
      k++;
    end
    if (!to) begin
      k = 0;
      forever begin
        cyc++;
        chk("wait_reqv", imem_req_valid, 32'h0);
        chk("wait_iv", instr_valid, 32'h0);
        data = $urandom;
        imem_rsp_data = data;
        imem_rsp_valid = (k == rsp_dly);
        imem_req_ready = 1'($urandom); enable = 1'($urandom);
        step;
        if (k == rsp_dly) break;
        if (cyc >= TO) begin to = 1'b1; break; end
        k++;
      end
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    if (to) begin
      chk("to_fault", fault, 32'h1);
      chk("to_reqv", imem_req_valid, 32'h0);
      chk("to_pc", pc, mpc);
      mfault = 1'b1;
      return;
    end
    enable = en_after; pc_jmp_dec = jmp; branch_taken = bt; imm = im;
    jalr_base = base; alu_result = alu; wr_en_dec = wren; wb_sel = wbs;
    imem_rsp_data = ~data;
    #1;
    case (jmp)
      2'd0:    tgt = mpc + 32'd4;
      2'd1:    tgt = mpc + im;
      2'd2:    tgt = bt ? mpc + im : mpc + 32'd4;
      default: tgt = (base + im) & 32'hFFFF_FFFE;
    endcase
    case (wbs)
      2'd2:    wexp = mpc + 32'd4;
      2'd3:    wexp = im;
      default: wexp = alu;
    endcase
    bad = (tgt[1:0] != 2'b00);
    chk("exec_iv", instr_valid, 32'h1);
    chk("exec_instr", instr, data);
    chk("exec_pc", pc, mpc);
    chk("exec_wdata", wr_data, wexp);
    chk("exec_rfwe", rf_wr_en, {31'b0, wren & ~bad});
    step;
    chk("post_rfwe", rf_wr_en, 32'h0);
    chk("post_iv", instr_valid, 32'h0);
    if (bad) begin
      mfault = 1'b1;
      chk("mis_fault", fault, 32'h1);
      chk("mis_pc", pc, mpc);
      chk("mis_instret", instret, mret);
      return;
    end
    mpc = tgt; mret = mret + 32'd1;
    chk("next_pc", pc, mpc);
    chk("instret", instret, mret);
    chk("no_fault", fault, 32'h0);
    if (!en_after) begin
      chk("idle_reqv", imem_req_valid, 32'h0);
      repeat (idle_cyc) begin
        step;
        chk("idle_hold", imem_req_valid, 32'h0);
      end
      enable = 1'b1;
      step;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd, rs;
    logic [31:0] ri, rb;
    do_reset;
    step;
    chk("idle_stay", imem_req_valid, 32'h0);

    enable = 1'b1; step;
    repeat (4) run_instr(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    chk("seq4_instret", instret, 32'd4);
    run_instr(0, 0, 2'd1, 0, 32'hFFFF_FFF0, 0, 0, 0, 2'd1, 1, 0);
    chk("rel_wrap", pc, 32'h0);
    run_instr(3, 2, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    repeat (3) run_instr(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    run_instr(1, 1, 2'd2, 0, 32'h40, 0, 0, 0, 2'd0, 1, 0);
    chk("br_nt", pc, 32'h14);
    run_instr(0, 0, 2'd3, 0, 32'h3, 32'h101, 0, 0, 2'd0, 1, 0);
    chk("jalr", pc, 32'h104);
    run_instr(0, 0, 2'd3, 0, 32'h0, 32'h20, 0, 0, 2'd0, 1, 0);
    run_instr(0, 0, 2'd0, 0, 32'h7, 0, 32'h55, 1, 2'd2, 0, 2);
    run_instr(0, 0, 2'd1, 0, 32'h2, 0, 32'h9, 1, 2'd1, 1, 0);
    hold_fault(5);

    do_reset; enable = 1'b1; step;
    run_instr(13, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    run_instr(14, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    hold_fault(2);
    do_reset; enable = 1'b1; step;
    run_instr(30, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    hold_fault(3);
    reset = 1'b1; enable = 1'b0; step; reset = 1'b0;
    chk("midflt_pc", pc, 32'h0);
    chk("midflt_fault", fault, 32'h0);
    step;
    chk("midflt_idle", imem_req_valid, 32'h0);
    mpc = 32'h0; mret = 32'h0; mfault = 1'b0;

    enable = 1'b1; step;
    for (int i = 0; i < 60; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 3));
      rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 3));
      ri = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) != 0) ri[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) rb[1:0] = 2'b00;
      run_instr(rd, rs, 2'($urandom), 1'($urandom), ri, rb, $urandom, 1'($urandom),
                2'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)));
      if (mfault) begin
        hold_fault(2);
        do_reset; enable = 1'b1; step;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
- Multi-cycle sequencer that supersedes direct PC-to-instruction-memory wiring in the core top.
- Owns the PC, instruction register, retired-instruction counter and writeback-data select.
- Fetches over a ready/valid instruction-memory interface with variable latency, then holds each instruction for one EXEC cycle while the existing decoder, register file and ALU act on it combinationally.
- Width, reset vector and fetch timeout are parametrised.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment and link offset.
- IMEM_TIMEOUT, 15, max cycles spent in FETCH+WAIT before FAULT; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run permission, sampled in IDLE and EXEC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  instruction data valid.
- imem_rsp_data  in  32  fetched instruction.
- instr  out  32  instruction register.
- instr_valid  out  1  high in EXEC only.
- pc_jmp_dec  in  2  next-PC select: 00 seq, 01 pc+imm, 10 branch, 11 jalr.
- branch_taken  in  1  ALU compare result (rout[0]).
- imm  in  XLEN  decoded immediate.
- jalr_base  in  XLEN  rs1 read data.
- wr_en_dec  in  1  decoder writeback request.
- wb_sel  in  2  01 ALU, 10 link (pc+PC_STEP), 11 imm, 00 ALU.
- alu_result  in  XLEN  ALU output.
- rf_wr_en  out  1  register-file write strobe.
- wr_data  out  XLEN  writeback data.
- pc  out  XLEN  current PC.
- instret  out  XLEN  retired-instruction count.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset state: pc=RESET_PC, instr=0, instret=0, state=IDLE, timeout count=0. All of fault, imem_req_valid, instr_valid and rf_wr_en are 0.
- Reset has priority in every state, including mid-fetch. Any in-flight response is discarded.
- FSM states are IDLE, FETCH, WAIT, EXEC and FAULT.
- IDLE:
  - All strobes are 0.
  - enable=1 moves to FETCH on the next cycle.
- FETCH:
  - imem_req_valid=1 and imem_req_addr=pc, both held stable until accepted.
  - imem_req_valid=1 && imem_req_ready=1 moves to WAIT.
  - enable is ignored here: once a request is raised, the instruction completes.
- WAIT:
  - The first imem_rsp_valid=1 latches imem_rsp_data into instr and moves to EXEC.
  - imem_rsp_valid is ignored in every other state.
- EXEC (exactly 1 cycle):
  - instr_valid=1 and rf_wr_en=wr_en_dec, unless a fault occurs this cycle.
  - Next PC by pc_jmp_dec:
    - 00: pc+PC_STEP.
    - 01: pc+imm.
    - 10: branch_taken ? pc+imm : pc+PC_STEP.
    - 11: (jalr_base+imm) with bit0 cleared.
  - All adds are modulo 2^XLEN; wrap is silent.
  - If the target has bits[1:0]≠0: go to FAULT. pc is not updated, rf_wr_en=0, instret is unchanged.
  - Otherwise: pc←target and instret←instret+1 (wraps). Then go to FETCH if enable=1, else IDLE.
- Minimum cost is 3 cycles per instruction (FETCH, WAIT, EXEC) with ready and rsp both asserted immediately.
- Timeout:
  - The counter clears on entry to FETCH and increments each cycle in FETCH or WAIT.
  - When the count reaches IMEM_TIMEOUT (≠0), the next state is FAULT.
  - Timeout loses to a simultaneous accept/response: the handshake wins.
- FAULT: fault=1, all strobes 0, pc frozen. Exit only via reset.
- wr_data is combinational from wb_sel at all times. The link value uses the pre-update pc.

Decomposition:
- Add to TypesPkg:
  - ctrl_state_t enum {IDLE, FETCH, WAIT, EXEC, FAULT}.
  - pc_sel_t enum for the four pc_jmp_dec codes.
  - wb_sel_t enum {WB_ALU=01, WB_LINK=10, WB_IMM=11}.
- One sub-module, next_pc_calc: combinational target computation plus misalignment flag, parametrised by XLEN and PC_STEP.
- The writeback mux stays inline.

Test Plan:
- Reset, enable=1, ready=1, rsp after 1 cycle, four pc_jmp_dec=00 instructions → imem_req_addr 0,4,8,12; instret=4 after 12 cycles; fault=0.
- Back-pressure: ready low 3 cycles, rsp low 2 cycles → imem_req_valid and imem_req_addr held stable throughout; EXEC occurs on the 7th cycle after entering FETCH; instret increments by 1.
- pc=0x10: pc_jmp_dec=01 with imm=0xFFFFFFF0 → pc=0x0. pc_jmp_dec=10 with branch_taken=0 → pc=0x14. pc_jmp_dec=11 with jalr_base=0x101, imm=0x3 → pc=0x104.
- wb_sel=10 at pc=0x20 with wr_en_dec=1 → rf_wr_en=1 for exactly one cycle, wr_data=0x24.
- Misaligned jump: pc_jmp_dec=01, imm=0x2 → FAULT, rf_wr_en=0, pc unchanged, instret unchanged, fault stays 1 until reset.
- Timeout: ready held 0 for 15 cycles → fault=1. Then reset=1 for one cycle mid-fault → pc=RESET_PC, fault=0, state IDLE.
